ai_mc_csr_master: RTL and testbench
===================================

AI_MC_CSR_MASTER -- requirements
Module: ai_mc_csr_master

Interface
REQ-001 Parameter CSR_ADDR_W, default 4, CSR bus address width.
REQ-002 Parameter CSR_DATA_W, default 32, CSR bus data width.
REQ-003 Parameter INIT_SPI_MODE, default 2'b00, boot value written to CSR 0x0.
REQ-004 Parameter INIT_CLK_DIV, default 8'd4, boot value written to CSR 0x1.
REQ-005 Parameter INIT_LEN, default 16'd16, boot value written to CSR 0x2.
REQ-006 Parameter INIT_ECC, default 1'b1, boot value written to CSR 0x3.
REQ-007 Parameter INIT_TIMEOUT, default 16'd1000, boot value written to CSR 0x4.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-010 req_valid  input  1  host request valid.
REQ-011 req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-012 req_we  input  1  1 = write, 0 = read.
REQ-013 req_addr  input  CSR_ADDR_W  CSR index.
REQ-014 req_wdata  input  CSR_DATA_W  write data.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  response consumed on an edge where rsp_valid && rsp_ready.
REQ-017 rsp_rdata  output  CSR_DATA_W  read data; 0 for writes and errors.
REQ-018 rsp_err  output  1  request addressed an unimplemented CSR.
REQ-019 init_done  output  1  boot sequence complete; sticky until reset.
REQ-020 cs, we  output  1 each  CSR bus select and write strobe.
REQ-021 addr  output  CSR_ADDR_W  CSR bus address.
REQ-022 wdata  output  CSR_DATA_W  CSR bus write data.
REQ-023 rdata  input  CSR_DATA_W  CSR bus read data, registered by the responder, valid the cycle after a read strobe.

Function
REQ-024 The block SHALL use states INIT, IDLE, WRITE, READ, READ_CAP, RESP.
REQ-025 INIT: a 3-bit index steps 0..4, one per cycle; each cycle drives cs=1, we=1, addr=index, wdata=zero-extended INIT_* value for that index.
REQ-026 After index 4, the block SHALL enter IDLE and set init_done=1; INIT lasts exactly 5 cycles with no gaps.
REQ-027 req_ready SHALL be 1 only in IDLE; in all other states req_valid is ignored.
REQ-028 On acceptance, req_we/req_addr/req_wdata SHALL be latched; the host may change them afterwards.
REQ-029 Latched addr > 4: the block SHALL skip bus access and go directly to RESP with rsp_err=1, rsp_rdata=0.
REQ-030 WRITE (one cycle): cs=1, we=1, addr/wdata = latched values; then RESP with rsp_rdata=0, rsp_err=0.
REQ-031 READ (one cycle): cs=1, we=0, addr = latched value; then READ_CAP.
REQ-032 READ_CAP (one cycle): cs=0; rdata SHALL be captured into rsp_rdata at the end of the cycle; then RESP with rsp_err=0.
REQ-033 Latency from accept edge to first rsp_valid cycle: write 2 cycles, read 3 cycles, error 1 cycle.
REQ-034 RESP: rsp_valid=1 with rsp_rdata/rsp_err held stable until rsp_ready=1; on that edge go to IDLE.
REQ-035 Back-to-back: a new request is accepted no earlier than the cycle after the response handshake.
REQ-036 Outside INIT/WRITE/READ: cs=0, we=0; addr and wdata SHALL hold their last driven values.
REQ-037 cs SHALL never be high for more than one cycle per host transaction.

Reset
REQ-038 While rst=0: cs=0, we=0, addr=0, wdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, state=INIT, index=0.
REQ-039 Reset asserted mid-transaction SHALL abort it immediately, with no response issued; after release, the full INIT sequence SHALL repeat.

Verification
REQ-040 Release reset -> cycles 1-5: cs=we=1, addr 0..4, wdata 0,4,16,1,1000; then init_done=1, req_ready=1.
REQ-041 Write addr=1, data=0x08 with rsp_ready=1 -> next cycle cs=we=1, addr=1, wdata=0x08; following cycle rsp_valid=1, rsp_rdata=0, rsp_err=0.
REQ-042 Read addr=2 with the responder returning 0x10 -> cs=1, we=0 one cycle; rsp_valid 3 cycles after accept with rsp_rdata=0x10.
REQ-043 Read addr=7 -> no cs pulse; rsp_valid the next cycle with rsp_err=1, rsp_rdata=0.
REQ-044 rsp_ready held 0 for 10 cycles -> rsp_valid and data stable, req_ready=0, no cs activity; accept resumes after the handshake.
REQ-045 rst=0 during READ -> cs drops asynchronously, no response; after release, 5-cycle INIT repeats before req_ready=1.

Source files
------------

// File: rtl/ai_mc_csr_master.sv
`default_nettype none
// ============================================================================
//  Module      : ai_mc_csr_master
//  Description : CSR bus master. After reset it writes five boot values to
//                CSRs 0..4, then serves single host read/write requests on a
//                valid/ready request and response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ai_mc_csr_master #(
   parameter int          CSR_ADDR_W    = 4,
   parameter int          CSR_DATA_W    = 32,
   parameter logic [1:0]  INIT_SPI_MODE = 2'b00,
   parameter logic [7:0]  INIT_CLK_DIV  = 8'd4,
   parameter logic [15:0] INIT_LEN      = 16'd16,
   parameter logic [0:0]  INIT_ECC      = 1'b1,
   parameter logic [15:0] INIT_TIMEOUT  = 16'd1000
) (
   input  logic                  clk,
   input  logic                  rst,
   // host request channel
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [CSR_ADDR_W-1:0] req_addr,
   input  logic [CSR_DATA_W-1:0] req_wdata,
   // host response channel
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [CSR_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done,
   // CSR bus
   output logic                  cs,
   output logic                  we,
   output logic [CSR_ADDR_W-1:0] addr,
   output logic [CSR_DATA_W-1:0] wdata,
   input  logic [CSR_DATA_W-1:0] rdata
);

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      IDLE     = 3'd1,
      WRITE    = 3'd2,
      READ     = 3'd3,
      READ_CAP = 3'd4,
      RESP     = 3'd5
   } state_t;

   localparam logic [2:0] c_LAST_INIT_IDX = 3'd4;

   state_t                r_state;
   state_t                w_state_next;

   // r_run is low only while reset is held, so the boot writes never show on
   // the bus before the first clock edge after release.
   logic                  r_run;
   logic [2:0]            r_idx;
   logic                  r_init_done;
   logic                  r_req_we;
   logic [CSR_ADDR_W-1:0] r_req_addr;
   logic [CSR_DATA_W-1:0] r_req_wdata;
   logic [CSR_DATA_W-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic [CSR_ADDR_W-1:0] r_bus_addr;
   logic [CSR_DATA_W-1:0] r_bus_wdata;

   logic                  w_drive;
   logic                  w_we;
   logic [CSR_ADDR_W-1:0] w_addr;
   logic [CSR_DATA_W-1:0] w_wdata;
   logic [CSR_DATA_W-1:0] w_init_value;
   logic                  w_accept;
   logic                  w_req_bad;

   // Only CSRs 0..4 exist; anything above is answered with an error.
   assign w_req_bad = (32'(req_addr) > 32'd4);

   // Boot value for the CSR currently addressed by the init index.
   always_comb begin
      w_init_value = '0;
      case (r_idx)
         3'd0:    w_init_value = CSR_DATA_W'(INIT_SPI_MODE);
         3'd1:    w_init_value = CSR_DATA_W'(INIT_CLK_DIV);
         3'd2:    w_init_value = CSR_DATA_W'(INIT_LEN);
         3'd3:    w_init_value = CSR_DATA_W'(INIT_ECC);
         3'd4:    w_init_value = CSR_DATA_W'(INIT_TIMEOUT);
         default: w_init_value = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and CSR bus drive; addr/wdata fall back to the held
   // values whenever the bus is idle.
   always_comb begin
      w_state_next = r_state;
      w_drive      = 1'b0;
      w_we         = 1'b0;
      w_addr       = r_bus_addr;
      w_wdata      = r_bus_wdata;
      w_accept     = 1'b0;
      case (r_state)
         INIT: begin
            if (r_run) begin
               w_drive = 1'b1;
               w_we    = 1'b1;
               w_addr  = CSR_ADDR_W'(r_idx);
               w_wdata = w_init_value;
               if (r_idx == c_LAST_INIT_IDX) begin
                  w_state_next = IDLE;
               end
            end
         end
         IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               if (w_req_bad) begin
                  w_state_next = RESP;
               end else if (req_we) begin
                  w_state_next = WRITE;
               end else begin
                  w_state_next = READ;
               end
            end
         end
         WRITE: begin
            w_drive      = 1'b1;
            w_we         = 1'b1;
            w_addr       = r_req_addr;
            w_wdata      = r_req_wdata;
            w_state_next = RESP;
         end
         READ: begin
            w_drive      = 1'b1;
            w_addr       = r_req_addr;
            w_state_next = READ_CAP;
         end
         READ_CAP: begin
            w_state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = INIT;
         end
      endcase
   end

   // Boot index, request latch, response capture and bus value hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run       <= 1'b0;
         r_idx       <= 3'd0;
         r_init_done <= 1'b0;
         r_req_we    <= 1'b0;
         r_req_addr  <= '0;
         r_req_wdata <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
      end else begin
         r_run <= 1'b1;
         if (r_state == INIT && r_run) begin
            if (r_idx == c_LAST_INIT_IDX) begin
               r_idx       <= 3'd0;
               r_init_done <= 1'b1;
            end else begin
               r_idx <= r_idx + 3'd1;
            end
         end
         if (w_drive) begin
            r_bus_addr  <= w_addr;
            r_bus_wdata <= w_wdata;
         end
         if (w_accept) begin
            r_req_we    <= req_we;
            r_req_addr  <= req_addr;
            r_req_wdata <= req_wdata;
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_req_bad;
         end
         // The responder registers rdata on the read strobe edge, so it is
         // valid during READ_CAP.
         if (r_state == READ_CAP) begin
            r_rsp_rdata <= rdata;
         end
      end
   end

   assign cs        = w_drive;
   assign we        = w_we;
   assign addr      = w_addr;
   assign wdata     = w_wdata;
   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ai_mc_csr_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ai_mc_csr_master
//  Description : Directed self-checking bench for ai_mc_csr_master, with a
//                small registered CSR responder model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ai_mc_csr_master;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;
   logic        cs;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int n_cmp;
   int n_bad;

   logic [31:0] mem [0:15];
   int          init_exp [0:4];

   ai_mc_csr_master dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .init_done (init_done),
      .cs        (cs),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered CSR responder: writes land in mem, reads return next cycle.
   always @(posedge clk) begin
      if (cs) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called right after reset release at a falling edge.
   task automatic check_init(input string pfx);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check({pfx, "_cs"},    32'(cs), 32'd1);
         check({pfx, "_we"},    32'(we), 32'd1);
         check({pfx, "_addr"},  32'(addr), 32'(i));
         check({pfx, "_wdata"}, wdata, 32'(init_exp[i]));
         check({pfx, "_rdy0"},  32'(req_ready), 32'd0);
         check({pfx, "_done0"}, 32'(init_done), 32'd0);
      end
      cyc(1);
      check({pfx, "_end_cs"},   32'(cs), 32'd0);
      check({pfx, "_end_done"}, 32'(init_done), 32'd1);
      check({pfx, "_end_rdy"},  32'(req_ready), 32'd1);
      check({pfx, "_hold_a"},   32'(addr), 32'd4);
      check({pfx, "_hold_d"},   wdata, 32'd1000);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      init_exp[0] = 0;
      init_exp[1] = 4;
      init_exp[2] = 16;
      init_exp[3] = 1;
      init_exp[4] = 1000;
      rdata     = 32'd0;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 4'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;

      // Reset state.
      cyc(2);
      check("rst_cs",    32'(cs), 32'd0);
      check("rst_we",    32'(we), 32'd0);
      check("rst_addr",  32'(addr), 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_rdy",   32'(req_ready), 32'd0);
      check("rst_rv",    32'(rsp_valid), 32'd0);
      check("rst_rd",    rsp_rdata, 32'd0);
      check("rst_err",   32'(rsp_err), 32'd0);
      check("rst_done",  32'(init_done), 32'd0);

      // Boot sequence.
      rst = 1'b1;
      check_init("init");

      // Write CSR1 = 0x08; host inputs change right after acceptance.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd1; req_wdata = 32'h08;
      cyc(1);
      check("wr_cs",    32'(cs), 32'd1);
      check("wr_we",    32'(we), 32'd1);
      check("wr_addr",  32'(addr), 32'd1);
      check("wr_wdata", wdata, 32'h08);
      check("wr_rdy",   32'(req_ready), 32'd0);
      check("wr_rv0",   32'(rsp_valid), 32'd0);
      req_valid = 1'b0; req_addr = 4'd3; req_wdata = 32'hdead;
      cyc(1);
      check("wr_rv",    32'(rsp_valid), 32'd1);
      check("wr_rd",    rsp_rdata, 32'd0);
      check("wr_err",   32'(rsp_err), 32'd0);
      check("wr_cs1",   32'(cs), 32'd0);
      cyc(1);
      check("wr_idle",  32'(req_ready), 32'd1);
      check("wr_rvoff", 32'(rsp_valid), 32'd0);
      check("wr_hold_a", 32'(addr), 32'd1);
      check("wr_hold_d", wdata, 32'h08);

      // Read CSR2, holds boot value 0x10.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
      cyc(1);
      check("rd_cs",   32'(cs), 32'd1);
      check("rd_we",   32'(we), 32'd0);
      check("rd_addr", 32'(addr), 32'd2);
      req_valid = 1'b0; req_addr = 4'd0;
      cyc(1);
      check("rd_cap_cs", 32'(cs), 32'd0);
      check("rd_cap_rv", 32'(rsp_valid), 32'd0);
      cyc(1);
      check("rd_rv",  32'(rsp_valid), 32'd1);
      check("rd_rd",  rsp_rdata, 32'h10);
      check("rd_err", 32'(rsp_err), 32'd0);
      cyc(1);
      check("rd_idle", 32'(req_ready), 32'd1);

      // Read unimplemented CSR7: error response, no bus access.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
      cyc(1);
      req_valid = 1'b0;
      check("err_cs",  32'(cs), 32'd0);
      check("err_rv",  32'(rsp_valid), 32'd1);
      check("err_err", 32'(rsp_err), 32'd1);
      check("err_rd",  rsp_rdata, 32'd0);
      cyc(1);
      check("err_idle", 32'(req_ready), 32'd1);
      check("err_errclr_rv", 32'(rsp_valid), 32'd0);

      // Stalled response: read CSR3 (=1) with rsp_ready low.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
      cyc(1);
      req_we = 1'b1; req_addr = 4'd0; req_wdata = 32'h5;
      cyc(2);
      for (int i = 0; i < 10; i++) begin
         check("stl_rv",  32'(rsp_valid), 32'd1);
         check("stl_rd",  rsp_rdata, 32'd1);
         check("stl_err", 32'(rsp_err), 32'd0);
         check("stl_rdy", 32'(req_ready), 32'd0);
         check("stl_cs",  32'(cs), 32'd0);
         cyc(1);
      end
      rsp_ready = 1'b1;
      cyc(1);
      check("stl_hs_rdy", 32'(req_ready), 32'd1);
      check("stl_hs_rv",  32'(rsp_valid), 32'd0);
      cyc(1);
      check("b2b_cs",    32'(cs), 32'd1);
      check("b2b_we",    32'(we), 32'd1);
      check("b2b_addr",  32'(addr), 32'd0);
      check("b2b_wdata", wdata, 32'h5);
      req_valid = 1'b0;
      cyc(1);
      check("b2b_rv", 32'(rsp_valid), 32'd1);
      check("b2b_rd", rsp_rdata, 32'd0);
      cyc(1);

      // Reset asserted during a READ.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
      cyc(1);
      check("mid_cs", 32'(cs), 32'd1);
      req_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("mid_cs_async", 32'(cs), 32'd0);
      check("mid_rv",       32'(rsp_valid), 32'd0);
      check("mid_done",     32'(init_done), 32'd0);
      check("mid_addr",     32'(addr), 32'd0);
      cyc(2);
      check("mid_rv2", 32'(rsp_valid), 32'd0);
      check("mid_rdy", 32'(req_ready), 32'd0);
      rst = 1'b1;
      check_init("reinit");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
